// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch
// Description : Instruction fetch stage. Issues single outstanding reads to
//               instruction memory at the current PC, tags each response with
//               its fetch address and buffers it in a small in-order queue
//               toward decode. A redirect (flush) empties the queue and
//               discards any response still in flight.
// Ports       : clk / rst_n          - clock, synchronous active-low reset
//               i_pc / o_pc_advance  - fetch address in, advance pulse out
//               i_flush              - branch/jump redirect
//               o_imem_*/i_imem_*    - instruction memory request/response
//               o_id_* / i_id_ready  - head-of-queue handshake to decode
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch #(
  parameter int DEPTH = 2               // queue entries, 2 or 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_pc,
  output logic        o_pc_advance,
  input  logic        i_flush,
  output logic        o_imem_req,
  output logic [15:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_id_valid,
  input  logic        i_id_ready,
  output logic [31:0] o_id_instr,
  output logic [15:0] o_id_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);
  localparam logic [PW-1:0] c_LAST  = PW'(DEPTH - 1);

  localparam logic [1:0] c_IDLE = 2'd0;  // nothing outstanding
  localparam logic [1:0] c_WAIT = 2'd1;  // one request outstanding
  localparam logic [1:0] c_DROP = 2'd2;  // outstanding response will be discarded

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [15:0]   r_tag;
  logic          r_stale;
  logic          w_req_ok;
  logic          w_grant;
  logic          w_push;
  logic          w_pop;

  logic [31:0]   r_instr [DEPTH];
  logic [15:0]   r_qpc   [DEPTH];

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_grant) begin
          w_state_nxt = c_WAIT;
        end
      end
      c_WAIT: begin
        // A response coinciding with a flush is consumed here and dropped.
        if (i_imem_rvalid) begin
          w_state_nxt = c_IDLE;
        end else if (i_flush) begin
          w_state_nxt = c_DROP;
        end
      end
      c_DROP: begin
        if (i_imem_rvalid) begin
          w_state_nxt = c_IDLE;
        end
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  // r_stale blocks new requests until the response to a request issued before
  // reset has drained, so it can never be mistaken for a fresh one.
  assign w_req_ok = rst_n & ~i_flush & ~r_stale & (r_count < c_DEPTH);

  always_comb begin
    o_imem_req = 1'b0;
    if (r_state == c_IDLE) begin
      o_imem_req = w_req_ok;
    end
    o_pc_advance = o_imem_req & i_imem_gnt;
  end

  assign w_grant     = o_pc_advance;
  assign o_imem_addr = i_pc;

  // --------------------------------------------------------------------------
  // Pre-reset response tracking
  // --------------------------------------------------------------------------
  // Held across a multi-cycle reset; a response arriving during reset also
  // retires the outstanding request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stale <= (r_stale | (r_state != c_IDLE)) & ~i_imem_rvalid;
    end else if (i_imem_rvalid) begin
      r_stale <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Instruction queue
  // --------------------------------------------------------------------------
  assign w_push = (r_state == c_WAIT) & i_imem_rvalid & ~i_flush;
  assign w_pop  = o_id_valid & i_id_ready & ~i_flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_tag   <= '0;
    end else begin
      if (w_grant) begin
        r_tag <= i_pc;
      end
      if (i_flush) begin
        r_count <= '0;
        r_wptr  <= '0;
        r_rptr  <= '0;
      end else begin
        if (w_push) begin
          r_wptr <= (r_wptr == c_LAST) ? '0 : r_wptr + PW'(1);
        end
        if (w_pop) begin
          r_rptr <= (r_rptr == c_LAST) ? '0 : r_rptr + PW'(1);
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + CW'(1);
        end else if (w_pop && !w_push) begin
          r_count <= r_count - CW'(1);
        end
      end
    end
  end

  // Storage needs no reset: entries are only observed while counted valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr[r_wptr] <= i_imem_rdata;
      r_qpc[r_wptr]   <= r_tag;
    end
  end

  assign o_id_valid = rst_n & (r_count != '0);
  assign o_id_instr = r_instr[r_rptr];
  assign o_id_pc    = r_qpc[r_rptr];

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch
// Description : Directed self-checking bench for if_fetch (DEPTH=2). A small
//               memory responder, PC stage and in-order scoreboard run in the
//               clock-step task; directed sequences check streaming,
//               backpressure, flush, wrap and reset behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [31:0] instr;
    logic [15:0] pc;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] pc;
  logic        pc_advance;
  logic        flush;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [15:0] id_pc;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_push = 0;
  int   n_pop  = 0;
  int   p0, q0;
  logic auto_mem;
  logic m_pend = 1'b0;
  logic m_kill = 1'b0;
  logic [15:0] m_tag = 16'h0;
  ent_t mq[$];

  if_fetch #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_pc         (pc),
    .o_pc_advance (pc_advance),
    .i_flush      (flush),
    .o_imem_req   (imem_req),
    .o_imem_addr  (imem_addr),
    .i_imem_gnt   (gnt),
    .i_imem_rvalid(rvalid),
    .i_imem_rdata (rdata),
    .o_id_valid   (id_valid),
    .i_id_ready   (id_ready),
    .o_id_instr   (id_instr),
    .o_id_pc      (id_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, then update the PC stage,
  // the memory responder and the scoreboard after it.
  task automatic tick();
    logic        g, rv, fl, pop, rs;
    logic [15:0] a, vpc;
    logic [31:0] rd, vin;
    ent_t        e;
    #1;
    g   = pc_advance;  a  = imem_addr;
    rv  = rvalid;      rd = rdata;
    fl  = flush;       rs = rst_n;
    pop = id_valid & id_ready & ~flush;
    vpc = id_pc;       vin = id_instr;
    @(posedge clk);
    #1;
    if (!rs) begin
      mq.delete();
      if (rv) m_pend = 1'b0;
      else if (m_pend) m_kill = 1'b1;
    end else begin
      if (rv && m_pend && !m_kill && !fl) begin
        chk("push_not_full", 32'(mq.size() < DEPTH), 1);
      end
      if (pop) begin
        chk("pop_nonempty", 32'(mq.size() > 0), 1);
        if (mq.size() > 0) begin
          e = mq.pop_front();
          chk("pop_pc", 32'(vpc), 32'(e.pc));
          chk("pop_instr", vin, e.instr);
        end
        n_pop++;
      end
      if (rv && m_pend && !m_kill && !fl) begin
        mq.push_back({rd, m_tag});
        n_push++;
      end
      if (rv) m_pend = 1'b0;
      else if (fl && m_pend) m_kill = 1'b1;
      if (fl) mq.delete();
      if (g) begin
        chk("one_outstanding", 32'(m_pend), 0);
        chk("adv_no_flush", 32'(fl), 0);
        m_pend = 1'b1;
        m_kill = 1'b0;
        m_tag  = a;
        pc     = pc + 16'd4;
      end
    end
    if (auto_mem) begin
      rvalid = g;
      rdata  = g ? {16'hC0DE, a} : 32'h0;
    end
    chk("id_valid", 32'(id_valid), 32'(mq.size() != 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; pc = 16'h0; flush = 1'b0; gnt = 1'b1;
    rvalid = 1'b0; rdata = 32'h0; id_ready = 1'b0; auto_mem = 1'b0;
    #2;
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_adv", 32'(pc_advance), 0);
    chk("rst_idv", 32'(id_valid), 0);
    tick(); tick();
    chk("rst_req2", 32'(imem_req), 0);
    chk("rst_adv2", 32'(pc_advance), 0);

    // Streaming: one instruction every two cycles, id_pc 0,4,8.
    rst_n = 1'b1; id_ready = 1'b1; auto_mem = 1'b1; pc = 16'h0; #1;
    chk("post_rst_idv", 32'(id_valid), 0);
    for (int k = 0; k < 3; k++) begin
      chk("st_adv", 32'(pc_advance), 1);
      chk("st_addr", 32'(imem_addr), 32'(k * 4));
      if (k > 0) begin
        chk("st_idpc", 32'(id_pc), 32'((k - 1) * 4));
        chk("st_instr", id_instr, 32'hC0DE0000 + 32'((k - 1) * 4));
      end
      tick(); #1;
      chk("st_wait_req", 32'(imem_req), 0);
      chk("st_wait_idv", 32'(id_valid), 0);
      tick(); #1;
    end
    gnt = 1'b0; #1;
    chk("st_last_pc", 32'(id_pc), 32'h0008);
    chk("st_last_instr", id_instr, 32'hC0DE0008);
    tick(); #1;
    chk("st_empty", 32'(id_valid), 0);

    // Backpressure: two grants fill the queue, then no request.
    id_ready = 1'b0; gnt = 1'b1; pc = 16'h0; #1;
    chk("bp_adv0", 32'(pc_advance), 1);
    chk("bp_addr0", 32'(imem_addr), 32'h0000);
    tick(); #1;
    chk("bp_wait0", 32'(imem_req), 0);
    tick(); #1;
    chk("bp_adv1", 32'(pc_advance), 1);
    chk("bp_addr1", 32'(imem_addr), 32'h0004);
    tick(); #1;
    chk("bp_wait1", 32'(imem_req), 0);
    tick(); #1;
    chk("bp_full_req", 32'(imem_req), 0);
    chk("bp_head", 32'(id_pc), 32'h0000);
    tick(); #1;
    chk("bp_full_req2", 32'(imem_req), 0);
    id_ready = 1'b1; #1;
    chk("bp_pop_first", 32'(id_pc), 32'h0000);
    chk("bp_pop_req", 32'(imem_req), 0);
    tick();
    id_ready = 1'b0; #1;
    chk("bp_reissue", 32'(pc_advance), 1);
    chk("bp_reissue_addr", 32'(imem_addr), 32'h0008);
    chk("bp_head2", 32'(id_pc), 32'h0004);
    tick();
    id_ready = 1'b1; gnt = 1'b0; #1;
    tick(); #1;
    chk("bp_head3", 32'(id_pc), 32'h0008);
    tick(); #1;
    chk("bp_drained", 32'(id_valid), 0);

    // Flush while a request is outstanding; response arrives later.
    auto_mem = 1'b0; gnt = 1'b1; pc = 16'h0010; #1;
    chk("fl_adv", 32'(pc_advance), 1);
    chk("fl_addr", 32'(imem_addr), 32'h0010);
    tick();
    flush = 1'b1; pc = 16'h0100; #1;
    chk("fl_req", 32'(imem_req), 0);
    chk("fl_adv_off", 32'(pc_advance), 0);
    tick();
    flush = 1'b0; #1;
    chk("fl_drop_req", 32'(imem_req), 0);
    tick();
    rvalid = 1'b1; rdata = 32'hDEADBEEF; #1;
    chk("fl_drop_req2", 32'(imem_req), 0);
    tick();
    rvalid = 1'b0; #1;
    chk("fl_dropped_idv", 32'(id_valid), 0);
    chk("fl_redirect_req", 32'(imem_req), 1);
    chk("fl_redirect_addr", 32'(imem_addr), 32'h0100);
    flush = 1'b1; #1;
    chk("fl_idle_req", 32'(imem_req), 0);
    flush = 1'b0; gnt = 1'b0;
    tick();

    // Flush together with a response while one entry is queued.
    id_ready = 1'b0; gnt = 1'b1; pc = 16'h0200; #1;
    chk("sf_adv0", 32'(pc_advance), 1);
    tick();
    rvalid = 1'b1; rdata = 32'h11111111; #1;
    tick();
    rvalid = 1'b0; #1;
    chk("sf_adv1", 32'(pc_advance), 1);
    chk("sf_addr1", 32'(imem_addr), 32'h0204);
    tick();
    gnt = 1'b0; id_ready = 1'b1; flush = 1'b1; rvalid = 1'b1; rdata = 32'h22222222; #1;
    chk("sf_idv", 32'(id_valid), 1);
    chk("sf_head", 32'(id_pc), 32'h0200);
    tick();
    flush = 1'b0; rvalid = 1'b0; #1;
    chk("sf_count0", 32'(id_valid), 0);
    chk("sf_idle", 32'(imem_req), 1);

    // Pointer wrap: five pushes interleaved with pops.
    auto_mem = 1'b1; gnt = 1'b1; pc = 16'h0300;
    p0 = n_push; q0 = n_pop;
    for (int i = 0; i < 40 && (n_push - p0) < 5; i++) begin
      id_ready = ((i % 3) != 0);
      #1;
      tick();
    end
    gnt = 1'b0; id_ready = 1'b1;
    for (int i = 0; i < 10 && mq.size() != 0; i++) begin
      #1;
      tick();
    end
    #1;
    chk("wrap_pushes", 32'(n_push - p0), 5);
    chk("wrap_pops", 32'(n_pop - q0), 5);
    chk("wrap_empty", 32'(id_valid), 0);

    // Reset while waiting; the stale response must be ignored.
    auto_mem = 1'b0; gnt = 1'b1; pc = 16'h0400; #1;
    chk("rw_adv", 32'(pc_advance), 1);
    tick();
    rst_n = 1'b0; #1;
    chk("rw_rst_req", 32'(imem_req), 0);
    chk("rw_rst_adv", 32'(pc_advance), 0);
    chk("rw_rst_idv", 32'(id_valid), 0);
    tick();
    rst_n = 1'b1; #1;
    chk("rw_stale_req", 32'(imem_req), 0);
    tick();
    rvalid = 1'b1; rdata = 32'hBAADF00D; #1;
    chk("rw_stale_req2", 32'(imem_req), 0);
    tick();
    rvalid = 1'b0; #1;
    chk("rw_stale_idv", 32'(id_valid), 0);
    chk("rw_resume_req", 32'(imem_req), 1);
    chk("rw_resume_addr", 32'(imem_addr), 32'h0404);
    gnt = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
